// File: rtl/updn_cmd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : updn_cmd_ctrl
//  Purpose  : Conditions raw buttons/switches into single-cycle load/up/down
//             commands with auto-repeat and limit suppression.
//  Revision : 1.0  initial release
// ============================================================================
module updn_cmd_ctrl #(
   parameter int DEB_CYCLES    = 16,
   parameter int REPEAT_DELAY  = 64,
   parameter int REPEAT_PERIOD = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       btn_load,
   input  logic [4:0] sw_in,
   input  logic       high,
   input  logic       low,
   output logic       load,
   output logic       up,
   output logic       down,
   output logic [4:0] in
);

   localparam int c_DEB_W   = $clog2(DEB_CYCLES);
   localparam int c_TMR_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int c_TMR_W   = $clog2(c_TMR_MAX + 1);

   localparam logic [c_DEB_W-1:0] c_DEB_LAST = c_DEB_W'(DEB_CYCLES - 1);
   localparam logic [c_TMR_W-1:0] c_DLY_LAST = c_TMR_W'(REPEAT_DELAY - 1);
   localparam logic [c_TMR_W-1:0] c_PER_LAST = c_TMR_W'(REPEAT_PERIOD - 1);

   localparam int c_UP = 0;
   localparam int c_DN = 1;
   localparam int c_LD = 2;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_DELAY  = 2'd1;
   localparam logic [1:0] S_REPEAT = 2'd2;
   localparam logic [1:0] S_LOCKED = 2'd3;

   logic [2:0] w_btn_raw;
   logic [2:0] w_lvl;
   logic [2:0] w_press;

   assign w_btn_raw = {btn_load, btn_down, btn_up};

   // w_lvl is the debounced level including a flip taking effect this edge,
   // so conflicts/releases are seen as early as the debouncer resolves them.
   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_btn
         logic               r_s1;
         logic               r_s2;
         logic               r_deb;
         logic               r_deb_d;
         logic               r_press;
         logic [c_DEB_W-1:0] r_cnt;
         logic               w_flip;

         assign w_flip = (r_s2 != r_deb) && (r_cnt == c_DEB_LAST);

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_s1    <= 1'b0;
               r_s2    <= 1'b0;
               r_deb   <= 1'b0;
               r_deb_d <= 1'b0;
               r_press <= 1'b0;
               r_cnt   <= '0;
            end else begin
               r_s1    <= w_btn_raw[gi];
               r_s2    <= r_s1;
               if ((r_s2 == r_deb) || w_flip)
                  r_cnt <= '0;
               else
                  r_cnt <= r_cnt + c_DEB_W'(1);
               if (w_flip)
                  r_deb <= ~r_deb;
               r_deb_d <= r_deb;
               r_press <= r_deb & ~r_deb_d;
            end
         end

         assign w_lvl[gi]   = r_deb ^ w_flip;
         assign w_press[gi] = r_press;
      end
   endgenerate

   logic [4:0] r_sw_s1;
   logic [4:0] r_sw_s2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sw_s1 <= '0;
         r_sw_s2 <= '0;
      end else begin
         r_sw_s1 <= sw_in;
         r_sw_s2 <= r_sw_s1;
      end
   end

   logic [1:0]         r_state;
   logic               r_dir;
   logic [c_TMR_W-1:0] r_tmr;
   logic [1:0]         w_state_nxt;
   logic               w_dir_nxt;
   logic [c_TMR_W-1:0] w_tmr_nxt;
   logic               w_fire;
   logic               w_fire_dn;
   logic               w_own;
   logic               w_oth;

   // r_dir selects the active button: 0 = up, 1 = down
   assign w_own = r_dir ? w_lvl[c_DN] : w_lvl[c_UP];
   assign w_oth = r_dir ? w_lvl[c_UP] : w_lvl[c_DN];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_dir   <= 1'b0;
         r_tmr   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_dir   <= w_dir_nxt;
         r_tmr   <= w_tmr_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_dir_nxt   = r_dir;
      w_tmr_nxt   = '0;
      w_fire      = 1'b0;
      w_fire_dn   = r_dir;
      if (w_press[c_LD]) begin
         w_state_nxt = S_LOCKED;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_lvl[c_UP] && w_lvl[c_DN]) begin
                  w_state_nxt = S_LOCKED;
               end else if (w_press[c_DN] && !w_lvl[c_UP]) begin
                  w_fire      = 1'b1;
                  w_fire_dn   = 1'b1;
                  w_dir_nxt   = 1'b1;
                  w_state_nxt = S_DELAY;
               end else if (w_press[c_UP] && !w_lvl[c_DN]) begin
                  w_fire      = 1'b1;
                  w_fire_dn   = 1'b0;
                  w_dir_nxt   = 1'b0;
                  w_state_nxt = S_DELAY;
               end
            end
            S_DELAY, S_REPEAT: begin
               if (w_oth) begin
                  w_state_nxt = S_LOCKED;
               end else if (!w_own) begin
                  w_state_nxt = S_IDLE;
               end else if (r_tmr == ((r_state == S_DELAY) ? c_DLY_LAST : c_PER_LAST)) begin
                  w_fire      = 1'b1;
                  w_state_nxt = S_REPEAT;
               end else begin
                  w_tmr_nxt = r_tmr + c_TMR_W'(1);
               end
            end
            S_LOCKED: begin
               if (!w_lvl[c_UP] && !w_lvl[c_DN])
                  w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   logic w_load_nxt;
   logic w_up_nxt;
   logic w_dn_nxt;

   // Limit flags only mask the pulse; the timer keeps its schedule.
   always_comb begin
      w_load_nxt = w_press[c_LD];
      w_up_nxt   = w_fire && !w_fire_dn && !high;
      w_dn_nxt   = w_fire &&  w_fire_dn && !low;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         load <= 1'b0;
         up   <= 1'b0;
         down <= 1'b0;
         in   <= '0;
      end else begin
         load <= w_load_nxt;
         up   <= w_up_nxt;
         down <= w_dn_nxt;
         if (w_load_nxt)
            in <= r_sw_s2;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_updn_cmd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_updn_cmd_ctrl
//  Purpose  : Directed + randomized bench for updn_cmd_ctrl with a
//             timestamp-based reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_updn_cmd_ctrl;

   localparam int DEB = 4;
   localparam int RD  = 10;
   localparam int RP  = 3;

   localparam int M_IDLE = 0;
   localparam int M_ACT  = 1;
   localparam int M_LOCK = 2;

   logic       clk      = 1'b0;
   logic       rst_n    = 1'b0;
   logic       btn_up   = 1'b0;
   logic       btn_down = 1'b0;
   logic       btn_load = 1'b0;
   logic [4:0] sw_in    = 5'd0;
   logic       high     = 1'b0;
   logic       low      = 1'b0;
   logic       load;
   logic       up;
   logic       down;
   logic [4:0] in;

   always #5 clk = ~clk;

   updn_cmd_ctrl #(
      .DEB_CYCLES   (DEB),
      .REPEAT_DELAY (RD),
      .REPEAT_PERIOD(RP)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .btn_up  (btn_up),
      .btn_down(btn_down),
      .btn_load(btn_load),
      .sw_in   (sw_in),
      .high    (high),
      .low     (low),
      .load    (load),
      .up      (up),
      .down    (down),
      .in      (in)
   );

   int vectors     = 0;
   int miscompares = 0;

   // Reference model: raw sample history, debounced-level history,
   // and a mode with an absolute due time for the next pulse.
   logic [2:0] bq[$];
   logic [4:0] swq[$];
   bit         dh[3][4];
   int         mode;
   int         due;
   int         t;
   bit         mdir;
   bit         el, eu, ed;
   logic [4:0] ein;

   task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic bit raw_at(input int b, input int back);
      int i;
      i = bq.size() - 1 - back;
      if (i < 0) return 1'b0;
      return bq[i][b];
   endfunction

   task automatic model_reset();
      bq.delete();
      swq.delete();
      for (int b = 0; b < 3; b++)
         for (int k = 0; k < 4; k++)
            dh[b][k] = 1'b0;
      mode = M_IDLE;
      mdir = 1'b0;
      due  = 0;
      t    = 0;
      el   = 1'b0;
      eu   = 1'b0;
      ed   = 1'b0;
      ein  = 5'd0;
   endtask

   task automatic model_edge();
      bit cand, same, nd;
      bit pu, pd, pl, lu, ld, own, oth;
      logic [4:0] sw2;
      bq.push_back({btn_load, btn_down, btn_up});
      swq.push_back(sw_in);
      if (bq.size() > 16) void'(bq.pop_front());
      if (swq.size() > 16) void'(swq.pop_front());
      // A level is accepted once DEB consecutive synchronised samples disagree with it.
      for (int b = 0; b < 3; b++) begin
         cand = raw_at(b, 2);
         same = 1'b1;
         for (int k = 1; k < DEB; k++)
            if (raw_at(b, 2 + k) != cand) same = 1'b0;
         nd = (same && cand != dh[b][0]) ? cand : dh[b][0];
         dh[b][3] = dh[b][2];
         dh[b][2] = dh[b][1];
         dh[b][1] = dh[b][0];
         dh[b][0] = nd;
      end
      pu  = dh[0][2] & ~dh[0][3];
      pd  = dh[1][2] & ~dh[1][3];
      pl  = dh[2][2] & ~dh[2][3];
      lu  = dh[0][0];
      ld  = dh[1][0];
      sw2 = (swq.size() >= 3) ? swq[swq.size() - 3] : 5'd0;
      el = 1'b0;
      eu = 1'b0;
      ed = 1'b0;
      if (pl) begin
         el   = 1'b1;
         ein  = sw2;
         mode = M_LOCK;
      end else if (mode == M_IDLE) begin
         if (lu && ld) begin
            mode = M_LOCK;
         end else if (pd && !lu) begin
            ed = !low;  mode = M_ACT; mdir = 1'b1; due = t + RD;
         end else if (pu && !ld) begin
            eu = !high; mode = M_ACT; mdir = 1'b0; due = t + RD;
         end
      end else if (mode == M_ACT) begin
         own = mdir ? ld : lu;
         oth = mdir ? lu : ld;
         if (oth) mode = M_LOCK;
         else if (!own) mode = M_IDLE;
         else if (t == due) begin
            if (mdir) ed = !low; else eu = !high;
            due = t + RP;
         end
      end else begin
         if (!lu && !ld) mode = M_IDLE;
      end
      t++;
   endtask

   task automatic check_outs(input string tag);
      chk({tag, ".load"}, {4'b0, load}, {4'b0, el});
      chk({tag, ".up"},   {4'b0, up},   {4'b0, eu});
      chk({tag, ".down"}, {4'b0, down}, {4'b0, ed});
      chk({tag, ".in"},   in,           ein);
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst_n) model_edge();
      #1;
      check_outs("model");
   endtask

   initial begin
      model_reset();
      #2;
      check_outs("reset");
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (3) tick();

      // Clean press with auto-repeat
      btn_up = 1'b1;
      for (int c = 0; c <= 26; c++) begin
         tick();
         chk("clean_up", {4'b0, up}, {4'b0, (c == 7 || c == 17 || c == 20 || c == 23 || c == 26)});
      end
      btn_up = 1'b0;
      repeat (12) tick();

      // Bounce on down, then a stable press
      repeat (4) begin
         btn_down = 1'b1;
         repeat ($urandom_range(1, 3)) tick();
         btn_down = 1'b0;
         repeat ($urandom_range(1, 3)) tick();
      end
      btn_down = 1'b1;
      for (int c = 0; c <= 15; c++) begin
         tick();
         chk("bounce_down", {4'b0, down}, {4'b0, (c == 7)});
      end
      btn_down = 1'b0;
      repeat (12) tick();

      // Load path
      sw_in    = 5'd19;
      btn_load = 1'b1;
      for (int c = 0; c <= 10; c++) begin
         tick();
         chk("load_pulse", {4'b0, load}, {4'b0, (c == 7)});
         chk("load_val", in, (c >= 7) ? 5'd19 : 5'd0);
      end
      btn_load = 1'b0;
      sw_in    = 5'd6;
      repeat (10) tick();
      chk("load_hold", in, 5'd19);

      // Limit suppression on up
      btn_up = 1'b1;
      for (int c = 0; c <= 27; c++) begin
         high = (c >= 15 && c <= 21);
         tick();
         chk("limit_up", {4'b0, up}, {4'b0, (c == 7 || c == 23 || c == 26)});
      end
      high   = 1'b0;
      btn_up = 1'b0;
      repeat (12) tick();

      // Limit suppression on down
      btn_down = 1'b1;
      for (int c = 0; c <= 27; c++) begin
         low = (c >= 15 && c <= 21);
         tick();
         chk("limit_down", {4'b0, down}, {4'b0, (c == 7 || c == 23 || c == 26)});
      end
      low      = 1'b0;
      btn_down = 1'b0;
      repeat (12) tick();

      // Conflict lock-out and recovery
      btn_up = 1'b1;
      for (int c = 0; c <= 30; c++) begin
         if (c == 12) btn_down = 1'b1;
         tick();
         chk("conflict_up", {4'b0, up}, {4'b0, (c == 7)});
         chk("conflict_down", {4'b0, down}, 5'd0);
      end
      btn_up   = 1'b0;
      btn_down = 1'b0;
      repeat (12) tick();
      btn_up = 1'b1;
      for (int c = 0; c <= 8; c++) begin
         tick();
         chk("fresh_up", {4'b0, up}, {4'b0, (c == 7)});
      end
      btn_up = 1'b0;
      repeat (12) tick();

      // Asynchronous reset during repeat
      btn_up = 1'b1;
      for (int c = 0; c <= 20; c++) tick();
      chk("pre_reset_up", {4'b0, up}, 5'd1);
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("async_up", {4'b0, up}, 5'd0);
      chk("async_in", in, 5'd0);
      repeat (2) tick();
      rst_n = 1'b1;
      for (int c = 0; c <= 8; c++) begin
         tick();
         chk("post_reset_up", {4'b0, up}, {4'b0, (c == 7)});
      end
      btn_up = 1'b0;
      repeat (12) tick();

      // Randomized operation against the model
      repeat (600) begin
         if ($urandom_range(0, 11) == 0) btn_up   = ~btn_up;
         if ($urandom_range(0, 11) == 0) btn_down = ~btn_down;
         if ($urandom_range(0, 29) == 0) btn_load = ~btn_load;
         if ($urandom_range(0, 14) == 0) high     = ~high;
         if ($urandom_range(0, 14) == 0) low      = ~low;
         sw_in = 5'($urandom_range(0, 31));
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/updn_cmd_ctrl.md
Name: updn_cmd_ctrl

Overview:
Front-end command stage for the 5-bit up/down counter. It conditions raw pushbuttons and the 5-bit switch bus into clean single-cycle load/up/down commands plus a registered load value, which drive the counter's control inputs directly. It synchronises and debounces the buttons and detects press edges. Held up/down buttons auto-repeat, and repeat is suppressed at the counter limits using the counter's high/low flags.

Parameters:
DEB_CYCLES, 16, consecutive stable synchronised samples required before a debounced button changes (>=2)
REPEAT_DELAY, 64, cycles from the initial press pulse to the first auto-repeat pulse (>=2)
REPEAT_PERIOD, 8, cycles between subsequent auto-repeat pulses (>=1)

Ports:
clk  input  1  single clock; all state updates on rising edge
rst_n  input  1  asynchronous, active-low reset
btn_up  input  1  raw up pushbutton, asynchronous, active-high
btn_down  input  1  raw down pushbutton, asynchronous, active-high
btn_load  input  1  raw load pushbutton, asynchronous, active-high
sw_in  input  5  raw switch value, asynchronous
high  input  1  counter-at-31 flag from the counter
low  input  1  counter-at-0 flag from the counter
load  output  1  one-cycle load command
up  output  1  one-cycle increment command
down  output  1  one-cycle decrement command
in  output  5  value to load; valid whenever load=1

Behaviour:
- Reset (rst_n=0, asynchronous): load=up=down=0 and in=0. All synchronisers, debounced states, debounce counters and timers clear. FSM goes to IDLE.
- Synchronisation: each button and each sw_in bit passes through a 2-flop synchroniser.
- Debounce, per button:
  - A counter increments while the synchronised value differs from the debounced value and clears on any match.
  - When it reaches DEB_CYCLES-1, the debounced value flips and the counter clears.
  - A glitch shorter than DEB_CYCLES cycles never changes the debounced value.
- Edge detect: a debounced 0->1 transition produces an internal press event for one cycle.
- Output timing: all outputs are registered. A clean press held stable produces its output pulse exactly DEB_CYCLES+3 cycles after the first rising clk edge that samples it high.
- Load path:
  - A load press asserts load for 1 cycle.
  - In the same cycle, in is loaded with the synchronised sw_in; otherwise in holds its value.
  - A load press aborts any repeat: FSM goes to LOCKED and no up/down pulse is issued in that cycle.
- FSM (up/down):
  - IDLE: a press of exactly one of up/down with the other debounced-low emits 1 pulse on that output, clears the timer and goes to DELAY.
  - IDLE: if both up and down are debounced-high, go to LOCKED with no pulse.
  - DELAY: the timer counts. At REPEAT_DELAY cycles after the initial pulse, emit a pulse, clear the timer and go to REPEAT.
  - REPEAT: emit a pulse every REPEAT_PERIOD cycles.
  - DELAY/REPEAT: release of the active button goes to IDLE with no pulse. Debounced assertion of the other button goes to LOCKED.
  - LOCKED: no up/down pulses. Exit to IDLE when both up and down are debounced-low.
- Limit suppression:
  - A pulse (initial or repeat) on up is masked when high=1; a pulse on down is masked when low=1. Both flags are sampled in the pulse cycle.
  - Timing continues while masked, so pulses resume on schedule once the flag clears.
- Mutual exclusion: at most one of load/up/down is high in any cycle. Priority is load > down > up.
- Timer width: clog2(max(REPEAT_DELAY, REPEAT_PERIOD)+1) bits. It never wraps because it clears on each pulse or state change.
- Reset mid-operation: all outputs drop immediately and asynchronously. After rst_n deasserts, a button still held counts as a new press only after full debounce from 0.

Test Plan:
- Bench parameters: DEB_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
- Clean press: btn_up held high, high=0 -> up pulses 1 cycle at cycle 7; repeats at cycles 17, 20, 23, ... until release; no pulses after release is debounced.
- Bounce: btn_down toggles with high-times of 1-3 cycles, then stays high -> exactly one initial down pulse, DEB_CYCLES+3 cycles after the stable high begins.
- Load: sw_in=5'd19, press btn_load -> load=1 for exactly 1 cycle with in=19; in stays 19 afterwards; up=down=0 throughout.
- Limits: hold btn_up with high=1 during cycles 15-21 -> the pulse at 17 is masked, pulses at 7, 23, 26 are present; mirror check for down with low.
- Conflict: hold btn_up, then assert btn_down at cycle 12 -> no further pulses; after both are released, a fresh up press gives an initial pulse again.
- Reset: assert rst_n=0 while in REPEAT -> outputs go to 0 immediately, in=0; release rst_n with btn_up still held -> a new initial pulse 7 cycles later.
